serial_learning_neuron: RTL and testbench

//  Parametrised, time-multiplexed successor of the 32-input learning neuron: one shared multiplier, one input/weight per cycle.

---
 rtl/serial_learning_neuron.sv | 195 +++++++++++++++++++
 tb/tb_serial_learning_neuron.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_learning_neuron.sv
// Time-multiplexed learning neuron: one input/weight pair per cycle.
// Forward pass accumulates x[i]*w[i] plus the bias, then saturates and
// optionally applies ReLU. Backward pass emits one back-propagated error per
// input and, if enabled, applies an in-place SGD update to each weight.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   init_en           load all weights from init_weights (idle only)
//   init_weights      packed weights, [i*DATA_W +: DATA_W] = w[i], w[N_INPUTS] = bias
//   fwd_start/in_vec  start a forward pass, inputs sampled with the start
//   bwd_start/err     start a backward pass, err and learn_en sampled with the start
//   learn_en          update weights during the backward pass
//   busy              pass in progress
//   out_valid/out     one-cycle result pulse, out held until the next result
//   grad_valid        back_err/grad_idx valid this cycle
//   grad_idx/back_err input index and the error propagated to it
//   done              one-cycle pulse at the end of a backward pass
module serial_learning_neuron #(
   parameter int unsigned N_INPUTS = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned FRAC_W   = 8,
   parameter int unsigned LR_SHIFT = 4,
   parameter int unsigned ACT      = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           init_en,
   input  logic [(N_INPUTS+1)*DATA_W-1:0] init_weights,
   input  logic                           fwd_start,
   input  logic [N_INPUTS*DATA_W-1:0]     in_vec,
   input  logic                           bwd_start,
   input  logic [DATA_W-1:0]              err,
   input  logic                           learn_en,
   output logic                           busy,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out,
   output logic                           grad_valid,
   output logic [$clog2(N_INPUTS)-1:0]    grad_idx,
   output logic [DATA_W-1:0]              back_err,
   output logic                           done
);

   localparam int unsigned IDX_W = $clog2(N_INPUTS);
   localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);
   localparam int unsigned AW    = 2 * DATA_W + CNT_W;

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_BWD} state_e;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q;
   logic signed [DATA_W-1:0]  w_q [N_INPUTS+1];
   logic signed [DATA_W-1:0]  x_q [N_INPUTS];
   logic signed [AW-1:0]      acc_q;
   logic signed [DATA_W-1:0]  z_q;
   logic signed [DATA_W-1:0]  delta_q;
   logic                      learn_q;
   logic                      fin_q;
   logic                      busy_q, out_valid_q, grad_valid_q, done_q;
   logic [DATA_W-1:0]         out_q, back_err_q;
   logic [IDX_W-1:0]          grad_idx_q;

   logic                      load_c, start_fwd_c, start_bwd_c, last_c;
   logic [IDX_W-1:0]          idx_c;
   logic signed [DATA_W-1:0]  mul_a_c, z_new_c, z_eff_c;
   logic signed [2*DATA_W-1:0] prod_c, prod_x_c;

   // Clamp a wide signed value into the DATA_W signed range.
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] v);
      logic [AW-DATA_W:0] top;
      top = v[AW-1:DATA_W-1];
      if (top == '0 || top == '1) return v[DATA_W-1:0];
      else if (v[AW-1])           return {1'b1, {(DATA_W-1){1'b0}}};
      else                        return {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   // Start decode: init beats fwd beats bwd, all only while idle.
   assign load_c      = (state_q == S_IDLE) && init_en;
   assign start_fwd_c = (state_q == S_IDLE) && !init_en && fwd_start;
   assign start_bwd_c = (state_q == S_IDLE) && !init_en && !fwd_start && bwd_start;
   assign last_c      = (cnt_q == CNT_W'(N_INPUTS));
   assign idx_c       = last_c ? '0 : cnt_q[IDX_W-1:0];

   // Shared multiplier: x*w in the forward pass, delta*w in the backward pass.
   assign mul_a_c  = (state_q == S_FWD) ? x_q[idx_c] : delta_q;
   assign prod_c   = mul_a_c * w_q[idx_c];
   assign prod_x_c = delta_q * x_q[idx_c];

   // Result of the pass that just finished is visible to a same-edge bwd_start.
   assign z_new_c = sat(acc_q >>> FRAC_W);
   assign z_eff_c = fin_q ? z_new_c : z_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_fwd_c)      state_d = S_FWD;
            else if (start_bwd_c) state_d = S_BWD;
         end
         S_FWD:   if (last_c) state_d = S_IDLE;
         S_BWD:   if (last_c) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: weights, latched inputs, accumulator and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         for (int i = 0; i <= int'(N_INPUTS); i++) w_q[i] <= '0;
         for (int i = 0; i < int'(N_INPUTS); i++)  x_q[i] <= '0;
         acc_q        <= '0;
         z_q          <= '0;
         delta_q      <= '0;
         learn_q      <= 1'b0;
         fin_q        <= 1'b0;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         grad_valid_q <= 1'b0;
         done_q       <= 1'b0;
         out_q        <= '0;
         back_err_q   <= '0;
         grad_idx_q   <= '0;
      end else begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         fin_q       <= 1'b0;
         busy_q      <= (state_d != S_IDLE);
         cnt_q       <= (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);

         // Final forward step runs one edge after the bias add, from idle.
         if (fin_q) begin
            z_q         <= z_new_c;
            out_q       <= (ACT != 0 && z_new_c[DATA_W-1]) ? '0 : z_new_c;
            out_valid_q <= 1'b1;
         end

         if (load_c)
            for (int i = 0; i <= int'(N_INPUTS); i++)
               w_q[i] <= init_weights[i*DATA_W +: DATA_W];

         if (start_fwd_c) begin
            for (int i = 0; i < int'(N_INPUTS); i++)
               x_q[i] <= in_vec[i*DATA_W +: DATA_W];
            acc_q <= '0;
         end

         // ReLU blocks the gradient when the pre-activation was not positive.
         if (start_bwd_c) begin
            delta_q <= (ACT != 0 && (z_eff_c[DATA_W-1] || z_eff_c == '0)) ? '0 : $signed(err);
            learn_q <= learn_en;
         end

         case (state_q)
            S_FWD: begin
               if (!last_c) begin
                  acc_q <= acc_q + AW'(prod_c);
               end else begin
                  acc_q <= acc_q + (AW'(w_q[N_INPUTS]) <<< FRAC_W);
                  fin_q <= 1'b1;
               end
            end
            S_BWD: begin
               if (!last_c) begin
                  grad_valid_q <= 1'b1;
                  grad_idx_q   <= idx_c;
                  back_err_q   <= sat(AW'(prod_c) >>> FRAC_W);
                  if (learn_q)
                     w_q[idx_c] <= sat(AW'(w_q[idx_c]) - (AW'(prod_x_c) >>> (FRAC_W + LR_SHIFT)));
               end else begin
                  grad_valid_q <= 1'b0;
                  done_q       <= 1'b1;
                  if (learn_q)
                     w_q[N_INPUTS] <= sat(AW'(w_q[N_INPUTS]) - (AW'(delta_q) >>> LR_SHIFT));
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = busy_q;
   assign out_valid  = out_valid_q;
   assign out        = out_q;
   assign grad_valid = grad_valid_q;
   assign grad_idx   = grad_idx_q;
   assign back_err   = back_err_q;
   assign done       = done_q;

endmodule

// File: tb/tb_serial_learning_neuron.sv
// Bench for serial_learning_neuron: a linear and a ReLU instance share all
// inputs; an array-based reference model predicts outputs and gradients.
module tb_serial_learning_neuron;

   localparam int N  = 32;
   localparam int DW = 32;
   localparam int F  = 8;
   localparam int LR = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n, init_en, fwd_start, bwd_start, learn_en;
   logic [(N+1)*DW-1:0]     init_weights;
   logic [N*DW-1:0]         in_vec;
   logic [DW-1:0]           err;
   logic                    busy [2], out_valid [2], grad_valid [2], done [2];
   logic [DW-1:0]           out [2], back_err [2];
   logic [4:0]              grad_idx [2];

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state, index 0 = linear instance, 1 = ReLU instance.
   longint wm [2][N+1];
   longint xm [N];
   longint zm [2];
   longint wl [N+1];

   serial_learning_neuron #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(F), .LR_SHIFT(LR), .ACT(0)) u_lin (
      .clk(clk), .rst_n(rst_n), .init_en(init_en), .init_weights(init_weights),
      .fwd_start(fwd_start), .in_vec(in_vec), .bwd_start(bwd_start), .err(err),
      .learn_en(learn_en), .busy(busy[0]), .out_valid(out_valid[0]), .out(out[0]),
      .grad_valid(grad_valid[0]), .grad_idx(grad_idx[0]), .back_err(back_err[0]), .done(done[0]));

   serial_learning_neuron #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(F), .LR_SHIFT(LR), .ACT(1)) u_relu (
      .clk(clk), .rst_n(rst_n), .init_en(init_en), .init_weights(init_weights),
      .fwd_start(fwd_start), .in_vec(in_vec), .bwd_start(bwd_start), .err(err),
      .learn_en(learn_en), .busy(busy[1]), .out_valid(out_valid[1]), .out(out[1]),
      .grad_valid(grad_valid[1]), .grad_idx(grad_idx[1]), .back_err(back_err[1]), .done(done[1]));

   function automatic longint sat(input longint v);
      if (v > 64'sd2147483647)  return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int a = 0; a < 2; a++) begin
         zm[a] = 0;
         for (int i = 0; i <= N; i++) wm[a][i] = 0;
      end
      for (int i = 0; i < N; i++) xm[i] = 0;
   endtask

   // Load wl into both instances via init_en.
   task automatic load_weights();
      for (int i = 0; i <= N; i++) begin
         init_weights[i*DW +: DW] = wl[i][DW-1:0];
         wm[0][i] = wl[i];
         wm[1][i] = wl[i];
      end
      init_en = 1'b1;
      tick();
      init_en = 1'b0;
   endtask

   // Forward pass with inputs xm; optionally pokes start inputs while busy.
   task automatic run_fwd(input bit poke);
      longint acc, eo [2];
      logic [DW-1:0] ev;
      int busy_cnt, vcnt, vcyc;
      for (int i = 0; i < N; i++) in_vec[i*DW +: DW] = xm[i][DW-1:0];
      for (int a = 0; a < 2; a++) begin
         acc = 0;
         for (int i = 0; i < N; i++) acc += xm[i] * wm[a][i];
         acc += wm[a][N] <<< F;
         zm[a] = sat(acc >>> F);
         eo[a] = (a == 1 && zm[a] < 0) ? 0 : zm[a];
      end
      fwd_start = 1'b1;
      tick();
      fwd_start = 1'b0;
      busy_cnt = 0; vcnt = 0; vcyc = -1;
      for (int cyc = 0; cyc <= 45; cyc++) begin
         if (cyc > 0) tick();
         fwd_start = poke && (cyc == 5);
         bwd_start = poke && (cyc == 5);
         if (busy[0]) busy_cnt++;
         if (out_valid[0]) begin
            vcnt++;
            if (vcyc < 0) vcyc = cyc;
            for (int a = 0; a < 2; a++) begin
               ev = eo[a][DW-1:0];
               tests_run++;
               if (out_valid[a] !== 1'b1 || out[a] !== ev) begin
                  tests_failed++;
                  $display("FAIL fwd_out[%0d]: got valid=%b out=%h, expected valid=1 out=%h", a, out_valid[a], out[a], ev);
               end
            end
         end
      end
      tests_run++;
      if (vcyc != N + 2 || vcnt != 1) begin
         tests_failed++;
         $display("FAIL fwd_latency: got first valid at %0d count %0d, expected %0d count 1", vcyc, vcnt, N + 2);
      end
      tests_run++;
      if (busy_cnt != N + 1) begin
         tests_failed++;
         $display("FAIL fwd_busy: got %0d busy cycles, expected %0d", busy_cnt, N + 1);
      end
   endtask

   // Backward pass; model uses pre-update weights for back_err.
   task automatic run_bwd(input longint e, input bit learn);
      longint delta [2];
      longint eb [2][N];
      logic [DW-1:0] ev;
      int gcnt, dcnt, dcyc;
      for (int a = 0; a < 2; a++) begin
         delta[a] = (a == 1 && zm[a] <= 0) ? 0 : e;
         for (int i = 0; i < N; i++) eb[a][i] = sat((delta[a] * wm[a][i]) >>> F);
         if (learn) begin
            for (int i = 0; i < N; i++)
               wm[a][i] = sat(wm[a][i] - ((delta[a] * xm[i]) >>> (F + LR)));
            wm[a][N] = sat(wm[a][N] - (delta[a] >>> LR));
         end
      end
      err = e[DW-1:0];
      learn_en = learn;
      bwd_start = 1'b1;
      tick();
      bwd_start = 1'b0;
      gcnt = 0; dcnt = 0; dcyc = -1;
      for (int cyc = 0; cyc <= 45; cyc++) begin
         if (cyc > 0) tick();
         if (grad_valid[0]) begin
            gcnt++;
            if (cyc < 1 || cyc > N) begin
               tests_run++;
               tests_failed++;
               $display("FAIL bwd_grad_window: grad_valid at cycle %0d, expected cycles 1..%0d", cyc, N);
            end else begin
               for (int a = 0; a < 2; a++) begin
                  ev = eb[a][cyc-1][DW-1:0];
                  tests_run++;
                  if (grad_valid[a] !== 1'b1 || grad_idx[a] !== 5'(cyc - 1) || back_err[a] !== ev) begin
                     tests_failed++;
                     $display("FAIL bwd_grad[%0d]: got v=%b idx=%0d err=%h, expected v=1 idx=%0d err=%h",
                              a, grad_valid[a], grad_idx[a], back_err[a], cyc - 1, ev);
                  end
               end
            end
         end
         if (done[0]) begin
            dcnt++;
            if (dcyc < 0) dcyc = cyc;
            tests_run++;
            if (done[1] !== 1'b1) begin
               tests_failed++;
               $display("FAIL bwd_done_relu: got %b, expected 1", done[1]);
            end
         end
      end
      tests_run++;
      if (gcnt != N || dcnt != 1 || dcyc != N + 1) begin
         tests_failed++;
         $display("FAIL bwd_timing: got %0d grads, %0d done at %0d, expected %0d grads, 1 done at %0d",
                  gcnt, dcnt, dcyc, N, N + 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; init_en = 1'b0; fwd_start = 1'b0; bwd_start = 1'b0; learn_en = 1'b0;
      init_weights = '0; in_vec = '0; err = '0;
      model_reset();
      tick();
      tick();
      for (int a = 0; a < 2; a++) begin
         tests_run++;
         if (busy[a] !== 1'b0 || out_valid[a] !== 1'b0 || out[a] !== '0 || grad_valid[a] !== 1'b0 ||
             grad_idx[a] !== '0 || back_err[a] !== '0 || done[a] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset[%0d]: got busy=%b ov=%b out=%h gv=%b idx=%0d be=%h done=%b, expected all 0",
                     a, busy[a], out_valid[a], out[a], grad_valid[a], grad_idx[a], back_err[a], done[a]);
         end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      for (int i = 0; i <= N; i++) wl[i] = 8;
      load_weights();
      for (int i = 0; i < N; i++) xm[i] = 0;
      run_fwd(1'b0);
      for (int i = 0; i <= N; i++) wl[i] = 256;
      load_weights();
      for (int i = 0; i < N; i++) xm[i] = 256;
      run_fwd(1'b1);
   endtask

   task automatic test_learn();
      run_bwd(256, 1'b1);
      run_fwd(1'b0);
   endtask

   task automatic test_saturation();
      for (int i = 0; i <= N; i++) wl[i] = 64'sd1 <<< 30;
      load_weights();
      for (int i = 0; i < N; i++) xm[i] = 4096;
      run_fwd(1'b0);
      for (int i = 0; i < N; i++) xm[i] = -4096;
      run_fwd(1'b0);
      run_bwd(64'sd1 <<< 20, 1'b0);
   endtask

   task automatic test_relu();
      for (int i = 0; i < N; i++) wl[i] = 0;
      wl[N] = -256;
      load_weights();
      for (int i = 0; i < N; i++) xm[i] = longint'($urandom_range(0, 2047)) - 1024;
      run_fwd(1'b0);
      run_bwd(256, 1'b1);
      run_fwd(1'b0);
   endtask

   task automatic test_priority();
      for (int i = 0; i <= N; i++) wl[i] = longint'($urandom_range(0, 511)) - 256;
      for (int i = 0; i <= N; i++) init_weights[i*DW +: DW] = wl[i][DW-1:0];
      init_en = 1'b1;
      fwd_start = 1'b1;
      bwd_start = 1'b1;
      tick();
      init_en = 1'b0; fwd_start = 1'b0; bwd_start = 1'b0;
      for (int i = 0; i <= N; i++) begin wm[0][i] = wl[i]; wm[1][i] = wl[i]; end
      tests_run++;
      if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL priority_busy: got %b/%b, expected 0/0", busy[0], busy[1]);
      end
      for (int i = 0; i < N; i++) xm[i] = longint'($urandom_range(0, 1023)) - 512;
      run_fwd(1'b0);
   endtask

   task automatic test_random();
      longint e;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i <= N; i++) wl[i] = longint'($urandom_range(0, 8191)) - 4096;
         load_weights();
         for (int i = 0; i < N; i++) xm[i] = longint'($urandom_range(0, 8191)) - 4096;
         run_fwd(1'b0);
         if (it % 2 == 1) e = longint'($urandom_range(0, 32'h7FFFFFFF)) - (64'sd1 <<< 30);
         else             e = longint'($urandom_range(0, 8191)) - 4096;
         run_bwd(e, 1'($urandom_range(0, 1)));
         run_fwd(1'b0);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < N; i++) in_vec[i*DW +: DW] = 32'd256;
      fwd_start = 1'b1;
      tick();
      fwd_start = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      rst_n = 1'b0;
      #1;
      for (int a = 0; a < 2; a++) begin
         tests_run++;
         if (busy[a] !== 1'b0 || out_valid[a] !== 1'b0 || out[a] !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid[%0d]: got busy=%b ov=%b out=%h, expected 0 0 0", a, busy[a], out_valid[a], out[a]);
         end
      end
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < N; i++) xm[i] = 256;
      run_fwd(1'b0);
      run_bwd(256, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_learn();
      test_saturation();
      test_relu();
      test_priority();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
